// File: rtl/fifo_flex.sv
// Single-clock FIFO with valid/ready on both sides, synchronous flush,
// runtime almost-full/almost-empty thresholds and a high-water mark.
module fifo_flex #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter bit          FULL_PUSH_POP = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  data_in_valid_i,
  output logic                  data_in_ready_o,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_out_valid_o,
  input  logic                  data_out_ready_i,
  output logic [DEPTH_LOG2:0]   count_o,
  input  logic [DEPTH_LOG2:0]   af_thr_i,
  input  logic [DEPTH_LOG2:0]   ae_thr_i,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  input  logic                  clear_peak_i,
  output logic [DEPTH_LOG2:0]   peak_o
);

  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef logic [PW-1:0]         ptr_t;
  typedef logic [DEPTH_LOG2-1:0] addr_t;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  ptr_t peak_q, peak_d;
  ptr_t count;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  addr_t wr_addr;
  addr_t rd_addr;
  logic  ptr_msb_diff;
  logic  empty;
  logic  full;
  logic  push;
  logic  pop;

  assign wr_addr      = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_addr      = rd_ptr_q[DEPTH_LOG2-1:0];
  assign ptr_msb_diff = wr_ptr_q[DEPTH_LOG2] ^ rd_ptr_q[DEPTH_LOG2];

  // Extra pointer MSB separates full from empty when the addresses match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ptr_msb_diff && (wr_addr == rd_addr);
  assign count = wr_ptr_q - rd_ptr_q;

  assign data_out_valid_o = !empty && !flush_i;
  assign data_out_o       = mem_q[rd_addr];

  // Full-push acceptance relies on the pop that is guaranteed when full.
  assign data_in_ready_o = !flush_i &&
                           (!full ||
                            (FULL_PUSH_POP && data_out_ready_i));

  assign push = data_in_valid_i && data_in_ready_o;
  assign pop  = data_out_valid_o && data_out_ready_i;

  assign count_o        = count;
  assign almost_full_o  = (count >= af_thr_i);
  assign almost_empty_o = (count <= ae_thr_i);
  assign peak_o         = peak_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
    end
  end

  always_comb begin
    peak_d = peak_q;
    if (clear_peak_i) begin
      peak_d = count;
    end else if (count > peak_q) begin
      peak_d = count;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      peak_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      peak_q   <= peak_d;
    end
  end

  // Storage is left unreset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_addr] <= data_in_i;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: two instances (plain and push-while-full)
// checked every cycle against queue models plus literal expectations.
module tb_fifo_flex;

  logic       clk;
  logic       arst_n;
  logic       flush;
  logic [7:0] din;
  logic       vin;
  logic       rdy_out;
  logic [4:0] af_thr;
  logic [4:0] ae_thr;
  logic       clr_pk;

  logic       rdy_o [2];
  logic       vld_o [2];
  logic [7:0] dout  [2];
  logic [4:0] cnt   [2];
  logic       af_o  [2];
  logic       ae_o  [2];
  logic [4:0] pk    [2];

  int nvec;
  int nfail;
  bit chk_en;

  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];
  int         mpk [2];

  fifo_flex #(
    .DEPTH_LOG2   (4),
    .DATA_WIDTH   (8),
    .FULL_PUSH_POP(1'b0)
  ) u0 (
    .clk_i           (clk),
    .arst_ni         (arst_n),
    .flush_i         (flush),
    .data_in_i       (din),
    .data_in_valid_i (vin),
    .data_in_ready_o (rdy_o[0]),
    .data_out_o      (dout[0]),
    .data_out_valid_o(vld_o[0]),
    .data_out_ready_i(rdy_out),
    .count_o         (cnt[0]),
    .af_thr_i        (af_thr),
    .ae_thr_i        (ae_thr),
    .almost_full_o   (af_o[0]),
    .almost_empty_o  (ae_o[0]),
    .clear_peak_i    (clr_pk),
    .peak_o          (pk[0])
  );

  fifo_flex #(
    .DEPTH_LOG2   (4),
    .DATA_WIDTH   (8),
    .FULL_PUSH_POP(1'b1)
  ) u1 (
    .clk_i           (clk),
    .arst_ni         (arst_n),
    .flush_i         (flush),
    .data_in_i       (din),
    .data_in_valid_i (vin),
    .data_in_ready_o (rdy_o[1]),
    .data_out_o      (dout[1]),
    .data_out_valid_o(vld_o[1]),
    .data_out_ready_i(rdy_out),
    .count_o         (cnt[1]),
    .af_thr_i        (af_thr),
    .ae_thr_i        (ae_thr),
    .almost_full_o   (af_o[1]),
    .almost_empty_o  (ae_o[1]),
    .clear_peak_i    (clr_pk),
    .peak_o          (pk[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int msize(input int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic int mhead(input int k);
    if (k == 0) return int'(mq0[0]);
    return int'(mq1[0]);
  endfunction

  function automatic bit m_ready(input int k);
    return !flush && (msize(k) < 16 || (k == 1 && rdy_out));
  endfunction

  function automatic bit m_valid(input int k);
    return !flush && msize(k) > 0;
  endfunction

  // Advance both queue models across one rising edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int sz;
      bit psh;
      bit pp;
      int npk;
      sz  = msize(k);
      psh = vin && m_ready(k);
      pp  = m_valid(k) && rdy_out;
      npk = clr_pk ? sz : ((sz > mpk[k]) ? sz : mpk[k]);
      if (!arst_n) begin
        if (k == 0) mq0.delete(); else mq1.delete();
        npk = 0;
      end else if (flush) begin
        if (k == 0) mq0.delete(); else mq1.delete();
      end else begin
        if (pp) begin
          if (k == 0) void'(mq0.pop_front());
          else void'(mq1.pop_front());
        end
        if (psh) begin
          if (k == 0) mq0.push_back(din); else mq1.push_back(din);
        end
      end
      mpk[k] = npk;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mpk[0] = 0;
    mpk[1] = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        sz = msize(k);
        chk($sformatf("u%0d.count", k), int'(cnt[k]), sz);
        chk($sformatf("u%0d.valid", k), int'(vld_o[k]), int'(m_valid(k)));
        chk($sformatf("u%0d.ready", k), int'(rdy_o[k]), int'(m_ready(k)));
        chk($sformatf("u%0d.af", k), int'(af_o[k]), int'(sz >= int'(af_thr)));
        chk($sformatf("u%0d.ae", k), int'(ae_o[k]), int'(sz <= int'(ae_thr)));
        chk($sformatf("u%0d.peak", k), int'(pk[k]), mpk[k]);
        if (m_valid(k)) begin
          chk($sformatf("u%0d.data", k), int'(dout[k]), mhead(k));
        end
      end
    end
  end

  initial begin
    nvec    = 0;
    nfail   = 0;
    chk_en  = 1'b0;
    arst_n  = 1'b0;
    flush   = 1'b0;
    din     = 8'h00;
    vin     = 1'b0;
    rdy_out = 1'b0;
    af_thr  = 5'd0;
    ae_thr  = 5'd3;
    clr_pk  = 1'b0;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk("rst.count", int'(cnt[k]), 0);
      chk("rst.valid", int'(vld_o[k]), 0);
      chk("rst.ready", int'(rdy_o[k]), 1);
      chk("rst.ae", int'(ae_o[k]), 1);
      chk("rst.af_thr0", int'(af_o[k]), 1);
      chk("rst.peak", int'(pk[k]), 0);
    end
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    chk_en = 1'b1;

    // Fill to 16 without pops
    for (int i = 0; i < 16; i++) begin
      vin = 1'b1;
      din = 8'(i + 1);
      cyc();
    end
    vin = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("fill.count", int'(cnt[k]), 16);
      chk("fill.ready", int'(rdy_o[k]), 0);
      chk("fill.valid", int'(vld_o[k]), 1);
      chk("fill.head", int'(dout[k]), 1);
    end

    // Drain in order
    rdy_out = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("drain.data", int'(dout[0]), i + 1);
      cyc();
    end
    rdy_out = 1'b0;
    #1;
    chk("drain.count", int'(cnt[0]), 0);
    chk("drain.valid", int'(vld_o[1]), 0);

    // Full + simultaneous push/pop
    for (int i = 0; i < 16; i++) begin
      vin = 1'b1;
      din = 8'(i + 1);
      cyc();
    end
    din     = 8'hAA;
    rdy_out = 1'b1;
    #1;
    chk("fpp0.ready", int'(rdy_o[0]), 0);
    chk("fpp1.ready", int'(rdy_o[1]), 1);
    cyc();
    vin = 1'b0;
    #1;
    chk("fpp0.count", int'(cnt[0]), 15);
    chk("fpp1.count", int'(cnt[1]), 16);
    for (int i = 0; i < 15; i++) cyc();
    chk("fpp1.last", int'(dout[1]), 8'hAA);
    chk("fpp0.empty", int'(vld_o[0]), 0);
    cyc();
    rdy_out = 1'b0;

    // Thresholds
    af_thr = 5'd12;
    ae_thr = 5'd3;
    for (int i = 0; i < 12; i++) begin
      vin = 1'b1;
      din = 8'(8'h30 + i);
      cyc();
      if (i == 10) chk("af.at11", int'(af_o[0]), 0);
    end
    vin = 1'b0;
    #1;
    chk("af.at12", int'(af_o[0]), 1);
    rdy_out = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (i == 7) chk("ae.at4", int'(ae_o[1]), 0);
    end
    rdy_out = 1'b0;
    #1;
    chk("ae.at3", int'(ae_o[1]), 1);
    af_thr = 5'd17;
    #1;
    chk("af.thr17", int'(af_o[0]), 0);
    af_thr = 5'd0;
    #1;
    chk("af.thr0", int'(af_o[0]), 1);

    // Flush with handshakes requested, peak retained
    rdy_out = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    rdy_out = 1'b0;
    clr_pk  = 1'b1;
    cyc();
    clr_pk = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vin = 1'b1;
      din = 8'(8'h50 + i);
      cyc();
    end
    vin    = 1'b0;
    ae_thr = 5'd16;
    #1;
    chk("ae.thr16", int'(ae_o[0]), 1);
    ae_thr = 5'd9;
    #1;
    chk("ae.thr9", int'(ae_o[0]), 0);
    chk("pk.pre", int'(pk[0]), 9);
    flush   = 1'b1;
    vin     = 1'b1;
    rdy_out = 1'b1;
    #1;
    chk("flush.ready", int'(rdy_o[1]), 0);
    chk("flush.valid", int'(vld_o[1]), 0);
    cyc();
    flush   = 1'b0;
    vin     = 1'b0;
    rdy_out = 1'b0;
    #1;
    chk("flush.count", int'(cnt[0]), 0);
    chk("flush.peak", int'(pk[1]), 10);

    // Reset mid-transfer
    for (int i = 0; i < 5; i++) begin
      vin = 1'b1;
      din = 8'(8'h70 + i);
      cyc();
    end
    din    = 8'h7F;
    arst_n = 1'b0;
    #1;
    chk("arst.count", int'(cnt[0]), 0);
    chk("arst.valid", int'(vld_o[1]), 0);
    chk("arst.peak", int'(pk[0]), 0);
    model_reset();
    vin = 1'b0;
    cyc();
    arst_n = 1'b1;

    // Random traffic then sustained streaming to force pointer wrap
    af_thr = 5'd10;
    ae_thr = 5'd2;
    for (int i = 0; i < 40; i++) begin
      vin     = ($urandom_range(7) != 0);
      rdy_out = ($urandom_range(3) != 0);
      din     = 8'($urandom_range(255));
      clr_pk  = ($urandom_range(15) == 0);
      cyc();
    end
    clr_pk = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vin     = 1'b1;
      rdy_out = 1'b1;
      din     = 8'(8'h80 + i);
      cyc();
    end
    vin = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    #1;
    chk("end.count", int'(cnt[0]), 0);
    chk("end.count1", int'(cnt[1]), 0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
